apb_mem_slave_gen2: RTL and testbench
=====================================

APB_MEM_SLAVE_GEN2 -- requirements
Module: apb_mem_slave_gen2

Interface
REQ-001 SHALL have parameter DATA_WDTH, default 32, bus width in bits, a multiple of 8 from 8 to 64.
REQ-002 SHALL have parameter ADDR_WDTH, default 12, byte-address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of DATA_WDTH-wide words.
REQ-004 SHALL have parameter BOUND_ADDR, default 1020, highest legal byte address.
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, ACCESS wait states, range 0..15.
REQ-006 pclk  input  1  clock; all logic on rising edge.
REQ-007 presetn  input  1  reset, asynchronous assertion, active-low.
REQ-008 psel  input  1  slave select.
REQ-009 penable  input  1  access phase.
REQ-010 pwrite  input  1  1 = write, 0 = read.
REQ-011 paddr  input  ADDR_WDTH  byte address.
REQ-012 pwdata  input  DATA_WDTH  write data.
REQ-013 pstrb  input  DATA_WDTH/8  byte write strobes (present only with APB_PSTRB_EN).
REQ-014 prdata  output  DATA_WDTH  read data.
REQ-015 pready  output  1  transfer complete.
REQ-016 pslverr  output  1  transfer error, valid only while pready=1.

Function
REQ-017 SHALL implement the FSM IDLE->SETUP (psel=1), SETUP->ACCESS (psel&penable), SETUP->IDLE (!psel), SETUP holds otherwise.
REQ-018 SHALL, in ACCESS, assert pready combinationally when the wait counter equals WAIT_CYCLES, so pready first rises WAIT_CYCLES+1 cycles after the SETUP cycle.
REQ-019 SHALL, on completion (pready=1), go to SETUP if psel=1, else IDLE.
REQ-020 SHALL go to IDLE with no write if psel drops while in ACCESS before pready (abort).
REQ-021 SHALL use word index paddr >> log2(DATA_WDTH/8); paddr low bits not equal to 0 is misaligned.
REQ-022 SHALL flag an error when paddr > BOUND_ADDR, word index >= MEM_DEPTH, or misaligned; pslverr=1 with pready.
REQ-023 SHALL commit a write only on the rising edge where psel&penable&pready=1 and no error; an errored write leaves memory unchanged.
REQ-024 SHALL drive prdata = mem[index] while a legal read has pready=1, else all zeros (including errored reads).
REQ-025 SHALL sample paddr/pwdata/pwrite at the completion cycle; their changes during wait states are not checked.
REQ-026 SHALL keep pready=0 and pslverr=0 in IDLE and SETUP.
REQ-027 SHALL reset the wait counter on each SETUP entry; the counter saturates at WAIT_CYCLES.
REQ-028 SHALL accept back-to-back transfers with a minimum of 2 cycles each (SETUP+ACCESS) when WAIT_CYCLES=0.

Reset
REQ-029 SHALL, on presetn=0, immediately force the FSM to IDLE, prdata=0, pready=0, pslverr=0, counter=0.
REQ-030 SHALL clear all memory words to 0 during reset; a reset mid-transfer discards the transfer.
REQ-031 SHALL release reset on the first rising pclk edge with presetn=1 and accept SETUP on that edge.

Configuration
REQ-032 SHALL, with APB_PSTRB_EN defined, provide pstrb and write byte b only where pstrb[b]=1; an all-zero strobe is a legal no-op with pslverr=0.
REQ-033 SHALL, without APB_PSTRB_EN, omit pstrb and write all bytes.

Structure
REQ-034 SHALL take the FSM state enum (IDLE, SETUP, ACCESS) and the error-reason constants from shared package apb_slv_pkg.
REQ-035 SHALL instantiate the wait-state counter as sub-module apb_wait_cntr (clear, enable, terminal-count compare).

Verification
REQ-036 Write 0xDEADBEEF to 0x010, read 0x010 with WAIT_CYCLES=0 -> pready in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
REQ-037 WAIT_CYCLES=3, read 0x000 -> pready low for 3 ACCESS cycles, high on the 4th, prdata=0.
REQ-038 Write to 0x400 (>BOUND_ADDR) and to 0x002 (misaligned) -> pslverr=1 with pready; a following read of 0x000 returns the old value.
REQ-039 With APB_PSTRB_EN, write 0x11223344 to 0x020 after 0xFFFFFFFF with pstrb=4'b0101 -> read returns 0xFF22FF44.
REQ-040 WAIT_CYCLES=5, deassert psel in the 2nd ACCESS cycle of a write, or assert presetn=0 mid-write -> FSM to IDLE, memory word unchanged (0 after reset).

Source files
------------

// File: rtl/apb_slv_pkg.sv
// Shared APB slave types: FSM state encoding and error-reason codes.
package apb_slv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef logic [1:0] err_rsn_t;

   localparam err_rsn_t ERR_NONE  = 2'd0;
   localparam err_rsn_t ERR_BOUND = 2'd1;
   localparam err_rsn_t ERR_RANGE = 2'd2;
   localparam err_rsn_t ERR_ALIGN = 2'd3;

endpackage

// File: rtl/apb_wait_cntr.sv
// Saturating wait-state counter; tc flags that MAX wait cycles have elapsed.
module apb_wait_cntr #(
   parameter int MAX = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && (cnt_q != 4'(MAX)))
         cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == 4'(MAX));

endmodule

// File: rtl/apb_mem_slave_gen2.sv
// APB memory slave with programmable wait states and address/alignment error checks.
// Define APB_PSTRB_EN to add the pstrb port and byte-masked writes.
module apb_mem_slave_gen2 #(
   parameter int DATA_WDTH   = 32,
   parameter int ADDR_WDTH   = 12,
   parameter int MEM_DEPTH   = 256,
   parameter int BOUND_ADDR  = 1020,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [ADDR_WDTH-1:0]   paddr,
   input  logic [DATA_WDTH-1:0]   pwdata,
`ifdef APB_PSTRB_EN
   input  logic [DATA_WDTH/8-1:0] pstrb,
`endif
   output logic [DATA_WDTH-1:0]   prdata,
   output logic                   pready,
   output logic                   pslverr
);
   import apb_slv_pkg::*;

   localparam int NBYTES = DATA_WDTH / 8;
   localparam int LSB    = $clog2(NBYTES);
   localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   apb_state_e             state_q, state_d;
   err_rsn_t               err_rsn;
   logic [ADDR_WDTH-1:0]   word_idx;
   logic [IDX_W-1:0]       mem_idx;
   logic [NBYTES-1:0]      be;
   logic [DATA_WDTH-1:0]   wr_word_d;
   logic [DATA_WDTH-1:0]   mem_q [MEM_DEPTH];
   logic                   access_cyc, tc, legal, we;

   assign word_idx = paddr >> LSB;
   assign mem_idx  = word_idx[IDX_W-1:0];

   always_comb begin
      err_rsn = ERR_NONE;
      if ((paddr & ADDR_WDTH'(NBYTES - 1)) != '0)
         err_rsn = ERR_ALIGN;
      else if (32'(paddr) > BOUND_ADDR)
         err_rsn = ERR_BOUND;
      else if (32'(word_idx) >= MEM_DEPTH)
         err_rsn = ERR_RANGE;
   end

   // The penable cycle right after setup already counts as the first access cycle,
   // so a zero-wait transfer completes while the FSM still reads SETUP.
   assign access_cyc = (state_q != IDLE) && psel && penable;
   assign pready     = access_cyc && tc;
   assign legal      = (err_rsn == ERR_NONE);
   assign pslverr    = pready && !legal;
   assign we         = pready && pwrite && legal;
   assign prdata     = (pready && !pwrite && legal) ? mem_q[mem_idx] : '0;

   apb_wait_cntr #(.MAX(WAIT_CYCLES)) u_wait_cntr (
      .clk   (pclk),
      .rst_n (presetn),
      .clr   (!access_cyc || pready),
      .en    (access_cyc),
      .tc    (tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (psel) state_d = SETUP;
         SETUP: begin
            if (!psel)        state_d = IDLE;
            else if (penable) state_d = pready ? SETUP : ACCESS;
         end
         ACCESS: begin
            if (!psel)                    state_d = IDLE;
            else if (pready || !penable)  state_d = SETUP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

`ifdef APB_PSTRB_EN
   assign be = pstrb;
`else
   assign be = '1;
`endif

   always_comb begin
      wr_word_d = mem_q[mem_idx];
      for (int b = 0; b < NBYTES; b++)
         if (be[b]) wr_word_d[8*b +: 8] = pwdata[8*b +: 8];
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[mem_idx] <= wr_word_d;
      end
   end

endmodule

// File: tb/tb_apb_mem_slave_gen2.sv
// Scoreboard bench: three slaves (0, 3, 5 wait states) against an array-based memory model.
module tb_apb_mem_slave_gen2;

   localparam int ND = 3;
   localparam logic [ND-1:0][3:0] WC = {4'd5, 4'd3, 4'd0};

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } exp_t;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        psel [ND];
   logic        penable [ND];
   logic        pwrite [ND];
   logic [11:0] paddr [ND];
   logic [31:0] pwdata [ND];
`ifdef APB_PSTRB_EN
   logic [3:0]  pstrb [ND];
`endif
   logic [31:0] prdata [ND];
   logic        pready [ND];
   logic        pslverr [ND];

   exp_t        exp_q [ND][$];
   logic [31:0] mdl [ND][256];
   int          acc_cnt [ND];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 pclk = ~pclk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      apb_mem_slave_gen2 #(.WAIT_CYCLES(int'(WC[g]))) u_dut (
         .pclk    (pclk),
         .presetn (presetn),
         .psel    (psel[g]),
         .penable (penable[g]),
         .pwrite  (pwrite[g]),
         .paddr   (paddr[g]),
         .pwdata  (pwdata[g]),
`ifdef APB_PSTRB_EN
         .pstrb   (pstrb[g]),
`endif
         .prdata  (prdata[g]),
         .pready  (pready[g]),
         .pslverr (pslverr[g])
      );
   end

   // Reference: word-addressed memory, byte lanes merged by strobe, errors from address rules.
   task automatic push_model(input int d, input logic wr, input logic [11:0] a,
                             input logic [31:0] wd, input logic [3:0] st_in);
      exp_t       e;
      logic [3:0] st;
      int         idx;
      st  = st_in;
`ifndef APB_PSTRB_EN
      st  = 4'hF;
`endif
      idx = int'(a) / 4;
      e.err   = (int'(a) > 1020) || (idx >= 256) || (int'(a) % 4 != 0);
      e.waits = int'(WC[d]);
      e.rdata = 32'h0;
      if (!e.err && !wr) e.rdata = mdl[d][idx];
      if (!e.err && wr)
         for (int b = 0; b < 4; b++)
            if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      exp_q[d].push_back(e);
   endtask

   task automatic drive_setup(input int d, input logic wr, input logic [11:0] a,
                              input logic [31:0] wd, input logic [3:0] st);
      @(posedge pclk); #1;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
`ifdef APB_PSTRB_EN
      pstrb[d] = st;
`endif
   endtask

   task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
      int n;
      drive_setup(d, wr, a, wd, st);
      push_model(d, wr, a, wd, st);
      @(posedge pclk); #1;
      penable[d] = 1'b1;
      n = 0;
      @(negedge pclk);
      while (!pready[d] && n < 40) begin
         n++;
         @(negedge pclk);
      end
      if (!pready[d]) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout dut%0d addr=%h: pready never rose within 40 cycles", d, a);
      end
   endtask

   task automatic idle(input int d, input int n);
      @(posedge pclk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
      repeat (n - 1) @(posedge pclk);
   endtask

   task automatic clear_model();
      for (int d = 0; d < ND; d++)
         for (int i = 0; i < 256; i++) mdl[d][i] = 32'h0;
   endtask

   // Monitor: every completed transfer is matched to the oldest expectation.
   always @(negedge pclk) begin
      exp_t e;
      for (int d = 0; d < ND; d++) begin
         if (presetn && psel[d] && penable[d]) begin
            if (pready[d]) begin
               n_cmp++;
               if (exp_q[d].size() == 0) begin
                  n_bad++;
                  $display("FAIL spurious_pready dut%0d addr=%h", d, paddr[d]);
               end else begin
                  e = exp_q[d].pop_front();
                  if (prdata[d] !== e.rdata || pslverr[d] !== e.err || acc_cnt[d] != e.waits) begin
                     n_bad++;
                     $display("FAIL xfer dut%0d addr=%h got rdata=%h err=%b waits=%0d exp rdata=%h err=%b waits=%0d",
                              d, paddr[d], prdata[d], pslverr[d], acc_cnt[d], e.rdata, e.err, e.waits);
                  end
               end
               acc_cnt[d] = 0;
            end else begin
               acc_cnt[d]++;
            end
         end else begin
            acc_cnt[d] = 0;
            if (presetn && psel[d] && !penable[d]) begin
               n_cmp++;
               if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0) begin
                  n_bad++;
                  $display("FAIL setup_quiet dut%0d got pready=%b pslverr=%b exp 0/0", d, pready[d], pslverr[d]);
               end
            end
         end
      end
   end

   initial begin
      for (int d = 0; d < ND; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
`ifdef APB_PSTRB_EN
         pstrb[d] = 4'hF;
`endif
      end
      clear_model();
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state dut%0d got pready=%b pslverr=%b prdata=%h exp 0/0/0",
                     d, pready[d], pslverr[d], prdata[d]);
         end
      end
      @(posedge pclk); #1;
      presetn = 1'b1;

      // Zero-wait write/read back-to-back, then 3-wait read of an untouched word.
      xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'hF);
      idle(0, 2);
      xfer(1, 1'b0, 12'h000, 32'h0, 4'hF);
      idle(1, 2);

      // Error writes leave memory alone; boundary address is legal.
      xfer(0, 1'b1, 12'h000, 32'hCAFEF00D, 4'hF);
      xfer(0, 1'b1, 12'h400, 32'h11111111, 4'hF);
      xfer(0, 1'b1, 12'h002, 32'h22222222, 4'hF);
      xfer(0, 1'b0, 12'h000, 32'h0, 4'hF);
      xfer(0, 1'b0, 12'h400, 32'h0, 4'hF);
      xfer(0, 1'b1, 12'h3FC, 32'h0BADC0DE, 4'hF);
      xfer(0, 1'b0, 12'h3FD, 32'h0, 4'hF);
      xfer(0, 1'b0, 12'h3FC, 32'h0, 4'hF);

      // Byte strobes (all lanes written when the strobe port is absent).
      xfer(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'hF);
      xfer(0, 1'b1, 12'h020, 32'h11223344, 4'b0101);
      xfer(0, 1'b0, 12'h020, 32'h0, 4'hF);
      xfer(0, 1'b1, 12'h024, 32'h5A5A5A5A, 4'hF);
      xfer(0, 1'b1, 12'h024, 32'h00000000, 4'h0);
      xfer(0, 1'b0, 12'h024, 32'h0, 4'hF);
      idle(0, 2);

      // Abort: psel drops in the 2nd access cycle of a 5-wait write.
      xfer(2, 1'b1, 12'h044, 32'h12345678, 4'hF);
      drive_setup(2, 1'b1, 12'h044, 32'hFFFFFFFF, 4'hF);
      @(posedge pclk); #1; penable[2] = 1'b1;
      @(posedge pclk); #1; psel[2] = 1'b0; penable[2] = 1'b0;
      repeat (2) @(posedge pclk);
      xfer(2, 1'b0, 12'h044, 32'h0, 4'hF);

      // Reset in the middle of a write discards it and clears memory.
      xfer(2, 1'b1, 12'h050, 32'hA5A5A5A5, 4'hF);
      drive_setup(2, 1'b1, 12'h050, 32'h3C3C3C3C, 4'hF);
      @(posedge pclk); #1; penable[2] = 1'b1;
      @(posedge pclk); @(posedge pclk); #1;
      presetn = 1'b0;
      #1;
      n_cmp++;
      if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 32'h0) begin
         n_bad++;
         $display("FAIL async_reset dut2 got pready=%b pslverr=%b prdata=%h exp 0/0/0",
                  pready[2], pslverr[2], prdata[2]);
      end
      psel[2] = 1'b0; penable[2] = 1'b0;
      clear_model();
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
      xfer(2, 1'b0, 12'h050, 32'h0, 4'hF);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'hF);
      idle(0, 1);
      idle(2, 1);

      // Randomized traffic on every slave.
      for (int d = 0; d < ND; d++) begin
         for (int k = 0; k < 40; k++) begin
            logic [11:0] a;
            int          r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = 12'($urandom_range(0, 15) * 4);
            else if (r == 7) a = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = 12'($urandom_range(1024, 4095));
            else             a = 12'h3FC;
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
         end
         idle(d, 2);
      end

      repeat (5) @(posedge pclk);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (exp_q[d].size() != 0) begin
            n_bad++;
            $display("FAIL drain dut%0d got %0d pending expectations exp 0", d, exp_q[d].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
